// File: rtl/imem_dmem_arbiter.sv
// Single-port arbiter for the unified program/data RAM: shares one 1-cycle-latency
// RAM between instruction fetch and load/store, with starvation guard, flush and halt drain.
module imem_dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          flush,
    input  logic          halt,
    output logic          halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       fetch_elig;
    logic       data_elig;
    logic       starve_hit;
    logic       rd_gnt;
    logic       fetch_pending;
    logic       data_pending;

    logic       vld_p1;
    logic       port_p1;
    logic       if_vld_p2;
    logic       dm_vld_p2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] sat_inc_starve(input logic [3:0] v);
        return (v >= STARVE_MAX) ? STARVE_MAX : v + 4'd1;
    endfunction

    // Arbitration and RAM command (grant cycle)
    always_comb begin
        fetch_elig    = !reset && if_req && (state == ST_RUN) && !flush;
        data_elig     = !reset && dm_req;
        starve_hit    = (starve_cnt == STARVE_MAX);
        if_gnt        = fetch_elig && (!data_elig || starve_hit);
        dm_gnt        = data_elig && !if_gnt;
        mem_en        = if_gnt || dm_gnt;
        mem_we        = dm_gnt && dm_we;
        mem_addr      = if_gnt ? if_addr : dm_addr;
        mem_wdata     = dm_wdata;
        rd_gnt        = if_gnt || (dm_gnt && !dm_we);
        // A flush kills the fetch tag in stage 1 before it can capture read data.
        fetch_pending = vld_p1 && !port_p1 && !flush;
        data_pending  = vld_p1 && port_p1;
    end

    // Grant N-2 is already registered when a flush arrives, so its valid is masked here.
    assign if_rvalid = if_vld_p2 && !flush;
    assign dm_rvalid = dm_vld_p2;

    // Stage 1: response tag registered at end of grant cycle
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            port_p1 <= 1'b0;
        end else begin
            vld_p1  <= rd_gnt;
            port_p1 <= dm_gnt;
        end
    end

    // Stage 2: RAM data captured into the owning port, valid in the following cycle
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            if_vld_p2 <= 1'b0;
            dm_vld_p2 <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_vld_p2 <= fetch_pending;
            dm_vld_p2 <= data_pending;
            if (fetch_pending) begin
                if_rdata <= mem_rdata;
            end
            if (data_pending) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'd0;
        end else if (fetch_elig) begin
            starve_cnt <= sat_inc_starve(starve_cnt);
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 16'd0;
        end else if (if_req && dm_req) begin
            conflict_cnt <= sat_inc16(conflict_cnt);
        end
    end

    // Halt sequencing; drain waits only for a fetch whose data has not yet been captured.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!fetch_pending) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: a RAM behind the DUT plus a transaction-level model
// (scheduled delivery queue, memory image, halt mode) checked every cycle.
module tb_imem_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SL = 4;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;

    logic          clk1 = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          flush;
    logic          halt;
    logic          halted;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   conflict_cnt;

    imem_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
        .clk1(clk1), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .flush(flush), .halt(halt), .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk1 = ~clk1;

    // Synchronous single-port RAM, one cycle read latency
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    assign mem_rdata = ram_q;
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    // Reference model
    typedef struct {
        int          due;
        bit          port;   // 1 = data port
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] m_mem [0:(1<<AW)-1];
    int          m_state;
    int          m_starve;
    int          m_conf;
    logic [31:0] exp_dm_rdata;
    bit          g_if, g_dm;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_state      = M_RUN;
        m_starve     = 0;
        m_conf       = 0;
        exp_dm_rdata = '0;
        g_if         = 0;
        g_dm         = 0;
    endtask

    // One clock cycle: inputs already applied just after a falling edge.
    task automatic step();
        bit          fe, de, e_ifg, e_dmg, e_ifrv, e_dmrv, fetch_left;
        logic [31:0] e_ifd;
        int          c;
        #1;
        c = cyc;
        if (flush) begin
            for (int i = pend.size() - 1; i >= 0; i--)
                if (!pend[i].port && (pend[i].due == c || pend[i].due == c + 1)) pend.delete(i);
        end
        e_ifrv = 0; e_dmrv = 0; e_ifd = '0;
        foreach (pend[i]) begin
            if (pend[i].due == c) begin
                if (pend[i].port) begin e_dmrv = 1; exp_dm_rdata = pend[i].data; end
                else begin e_ifrv = 1; e_ifd = pend[i].data; end
            end
        end
        fe    = if_req && (m_state == M_RUN) && !flush;
        de    = dm_req;
        e_ifg = fe && (!de || m_starve == SL);
        e_dmg = de && !e_ifg;

        chk("if_gnt", 32'(if_gnt), 32'(e_ifg));
        chk("dm_gnt", 32'(dm_gnt), 32'(e_dmg));
        chk("mem_en", 32'(mem_en), 32'(e_ifg || e_dmg));
        if (e_ifg || e_dmg) begin
            chk("mem_we", 32'(mem_we), 32'(e_dmg && dm_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_ifg ? if_addr : dm_addr));
            if (e_dmg && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
        end
        chk("if_rvalid", 32'(if_rvalid), 32'(e_ifrv));
        if (e_ifrv) chk("if_rdata", if_rdata, e_ifd);
        chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dmrv));
        chk("dm_rdata", dm_rdata, exp_dm_rdata);
        chk("halted", 32'(halted), 32'(m_state == M_HALTED));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due <= c) pend.delete(i);
        if (e_ifg) pend.push_back('{c + 2, 1'b0, m_mem[if_addr]});
        if (e_dmg) begin
            if (dm_we) m_mem[dm_addr] = dm_wdata;
            else       pend.push_back('{c + 2, 1'b1, m_mem[dm_addr]});
        end
        if (e_ifg || !if_req)     m_starve = 0;
        else if (fe && m_starve < SL) m_starve++;
        if (if_req && dm_req && m_conf != 32'hFFFF) m_conf++;
        fetch_left = 0;
        foreach (pend[i]) if (!pend[i].port && pend[i].due > c) fetch_left = 1;
        if (m_state == M_RUN && halt)              m_state = M_DRAIN;
        else if (m_state == M_DRAIN && !fetch_left) m_state = M_HALTED;
        g_if = e_ifg;
        g_dm = e_dmg;
        @(posedge clk1);
        @(negedge clk1);
        cyc++;
    endtask

    // Random requester honouring hold-until-grant
    task automatic gen(input bit allow_flush, input bit allow_halt);
        if (!if_req || g_if) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = AW'($urandom);
        end
        if (!dm_req || g_dm) begin
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = ($urandom_range(0, 2) == 0);
            dm_addr  = AW'($urandom_range(0, 15));
            dm_wdata = $urandom;
        end
        flush = allow_flush && ($urandom_range(0, 7) == 0);
        halt  = allow_halt && ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = $urandom;
            m_mem[i] = ram[i];
        end
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
        m_mem[0] = 32'h11; m_mem[1] = 32'h22; m_mem[2] = 32'h33;
        ram_q = '0;
        cyc = 0;
        model_reset();

        // Reset state with both requests raised
        reset = 1; if_req = 1; if_addr = 0; dm_req = 1; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; flush = 0; halt = 0;
        #2;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_dm_gnt", 32'(dm_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_conflict", 32'(conflict_cnt), 0);
        @(negedge clk1);
        reset = 0; if_req = 0; dm_req = 0;

        // Fetch-only stream from addresses 0,1,2
        for (int i = 0; i < 3; i++) begin
            if_req = 1; if_addr = AW'(i);
            step();
        end
        if_req = 0;
        repeat (3) step();

        // Continuous contention: D,D,D,D,F pattern
        if_req = 1; if_addr = 8'h40; dm_req = 1; dm_we = 0; dm_addr = 8'h03;
        repeat (20) begin
            step();
            if (g_if) if_addr = if_addr + 1;
            if (g_dm) dm_addr = dm_addr + 1;
        end
        if_req = 0; dm_req = 0;
        repeat (3) step();

        // Store then load to the same address
        dm_req = 1; dm_we = 1; dm_addr = 8'h10; dm_wdata = 32'hDEADBEEF;
        step();
        dm_we = 0; dm_wdata = 0;
        step();
        dm_req = 0;
        repeat (3) step();

        // Flush kills two in-flight fetches, later fetch returns normally
        if_req = 1; if_addr = 8'h05; step();
        if_addr = 8'h06; step();
        if_addr = 8'h07; flush = 1; step();
        flush = 0; step();
        if_req = 0;
        repeat (3) step();

        // Randomized traffic with flushes
        repeat (300) begin
            gen(1'b1, 1'b0);
            step();
        end
        if_req = 0; dm_req = 0; flush = 0;
        repeat (3) step();

        // Halt with a fetch in flight, then random traffic incl. repeated halts
        if_req = 1; if_addr = 8'h20; step();
        if_addr = 8'h21; halt = 1; step();
        halt = 0;
        repeat (60) begin
            gen(1'b0, 1'b1);
            step();
        end

        // Reset during an outstanding load
        if_req = 1; if_addr = 8'h01; dm_req = 1; dm_we = 0; dm_addr = 8'h02; flush = 0; halt = 0;
        step();
        if_req = 1; dm_req = 0;
        #2 reset = 1;
        #1;
        chk("mid_rst_if_gnt", 32'(if_gnt), 0);
        chk("mid_rst_mem_en", 32'(mem_en), 0);
        chk("mid_rst_dm_rvalid", 32'(dm_rvalid), 0);
        chk("mid_rst_dm_rdata", dm_rdata, 0);
        chk("mid_rst_if_rdata", if_rdata, 0);
        chk("mid_rst_halted", 32'(halted), 0);
        chk("mid_rst_conflict", 32'(conflict_cnt), 0);
        @(negedge clk1);
        reset = 0; if_req = 0; dm_req = 0;
        model_reset();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Single-port arbiter and sequencer for the processor's unified 256x32 program/data memory.
- Shares the memory between the instruction-fetch port and the load/store (MEM stage) port.
- Handles fetch starvation protection, branch-flush suppression of in-flight fetch responses, and halt draining.
- Sits between the pipeline stages and one synchronous single-port RAM with 1-cycle read latency.

Parameters:
AW, 8, memory address width (words)
DW, 32, data width
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins one arbitration (1..15)

Ports:
clk1 input 1 single clock, all state on rising edge
reset input 1 asynchronous, active-high reset
if_req input 1 fetch request; held with if_addr until if_gnt
if_addr input AW fetch word address
if_gnt output 1 fetch granted this cycle (combinational)
if_rvalid output 1 fetch read data valid
if_rdata output DW fetch read data (registered)
dm_req input 1 data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
dm_we input 1 1=store, 0=load
dm_addr input AW data word address
dm_wdata input DW store data
dm_gnt output 1 data granted this cycle (combinational)
dm_rvalid output 1 load data valid
dm_rdata output DW load data (registered)
flush input 1 taken branch; discard pending fetch responses
halt input 1 Halt retired; pulse, sticky internally
halted output 1 arbiter in HALTED state
mem_en output 1 RAM enable
mem_we output 1 RAM write enable
mem_addr output AW RAM address
mem_wdata output DW RAM write data
mem_rdata input DW RAM read data, valid cycle after mem_en&!mem_we
conflict_cnt output 16 count of cycles both ports requested, saturating at 16'hFFFF

Behaviour:
- Reset (asynchronous): if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0, halted=0, state RUN, starve counter=0, conflict_cnt=0, in-flight tags cleared. While reset is high, if_gnt=dm_gnt=mem_en=mem_we=0. A response in flight when reset asserts is never delivered.
- Arbitration, combinational in cycle N, one grant per cycle at most:
  - Fetch is eligible only when if_req=1, state=RUN and flush=0.
  - Data is eligible when dm_req=1, in every state.
  - Both eligible: data wins, unless starve counter==STARVE_LIMIT, in which case fetch wins.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle fetch is eligible but not granted.
  - Clears on if_gnt, or when if_req=0.
- RAM command, same cycle as grant: mem_en=1, mem_addr=winner address, mem_we=dm_we for data grant (0 for fetch), mem_wdata=dm_wdata. Otherwise mem_en=0, mem_we=0, with mem_addr/mem_wdata don't-care.
- Response pipeline (read grant in N):
  - Tag {valid, port} registered at end of N (stage 1).
  - mem_rdata captured into if_rdata or dm_rdata at end of N+1.
  - rvalid is high in N+2 for exactly one cycle.
  - Read latency is 2 cycles from grant. Back-to-back grants yield back-to-back rvalids.
  - Stores produce no rvalid.
  - rdata holds its last value when rvalid=0.
- Flush in cycle N: fetch tags in stages 1 and 2 (grants in N-1, N-2) are killed, so no if_rvalid appears for them. No fetch grant occurs in N. Data tags are unaffected.
- State machine:
  - RUN: on halt=1, go to DRAIN.
  - DRAIN: no fetch grants. When no fetch tag is in flight, go to HALTED.
  - HALTED: halted=1, no fetch grants, data port fully served. Only reset exits.
  - halt while already in DRAIN or HALTED is ignored.
- conflict_cnt increments each cycle with if_req&dm_req, regardless of state.
- Same-address store in N followed by load in N+1 returns the stored data (RAM ordering; no bypass needed).

Test Plan:
- Fetch only, if_req=1, addrs 0,1,2 with RAM preloaded 0x11,0x22,0x33 -> if_gnt each cycle; if_rvalid in cycles 2,3,4 with data 0x11,0x22,0x33.
- Continuous if_req and dm_req (loads), STARVE_LIMIT=4 -> grant pattern D,D,D,D,F repeating; conflict_cnt increments every cycle.
- Store 0xDEADBEEF to addr 0x10, then load addr 0x10 next cycle -> no dm_rvalid for the store; dm_rvalid 2 cycles after the load grant with 0xDEADBEEF.
- Fetch grants at cycles 5,6, flush at cycle 7 -> no if_rvalid at cycles 7,8; no if_gnt at 7; a fetch grant at 8 returns if_rvalid at 10.
- halt pulse with one fetch in flight -> DRAIN for 1-2 cycles, then halted=1; later if_req is never granted; a dm load still returns data.
- Assert reset during an outstanding load -> all outputs return to reset values immediately; no dm_rvalid after reset release.
